// File: rtl/array_mult_chk_pkg.sv
// rtl/array_mult_chk_pkg.sv - shared types and helpers for the array multiplier response checker
// Purpose: FSM state encoding and the iteration-counter width helper.
// Ports: none (package).
package array_mult_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_CMP  = 2'd2
  } chk_state_e;

  // The iteration counter must be able to hold the value N itself.
  function automatic int iter_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/shift_add_mult_core.sv
// rtl/shift_add_mult_core.sv - iterative shift-add reference multiplier
// Purpose: recomputes a*x one multiplier bit per step, fixed N steps.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   start          load a/x, clear accumulator and iteration count
//   step           perform one shift-add iteration
//   a [M], x [N]   operands sampled on start
//   last           N iterations have been performed
//   product [M+N]  accumulated product (valid when last)
module shift_add_mult_core
  import array_mult_chk_pkg::*;
#(
  parameter int M = 8,
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           step,
  input  logic [M-1:0]   a,
  input  logic [N-1:0]   x,
  output logic           last,
  output logic [M+N-1:0] product
);

  localparam int IW = iter_width(N);

  logic [M+N-1:0] acc_q, acc_d;
  logic [M+N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [IW-1:0]  iter_q, iter_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    iter_d   = iter_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{N{1'b0}}, a};
      mplier_d = x;
      iter_d   = '0;
    end else if (step) begin
      // acc cannot overflow: the final sum is at most (2^M-1)*(2^N-1).
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      iter_d   = iter_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      iter_q   <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      iter_q   <= iter_d;
    end
  end

  assign last    = (iter_q == IW'(N));
  assign product = acc_q;

endmodule

// File: rtl/array_mult_response_checker.sv
// rtl/array_mult_response_checker.sv - checks (a, x, p) triples from a multiplier under test
// Purpose: recompute a*x, compare with reported p, keep saturating counters and the first failure.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   clr                        sync clear of counters and first-error record
//   in_valid/in_ready          triple handshake (ready only in IDLE)
//   in_a [M], in_x [N], in_p   operands and reported product [M+N]
//   busy, chk_done, chk_pass   check in flight, result pulse, held result
//   vec_cnt, err_cnt [CNT_W]   saturating vector and mismatch counters
//   first_err_v/a/x/p          first mismatching triple
module array_mult_response_checker
  import array_mult_chk_pkg::*;
#(
  parameter int M     = 8,
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M-1:0]     in_a,
  input  logic [N-1:0]     in_x,
  input  logic [M+N-1:0]   in_p,
  output logic             busy,
  output logic             chk_done,
  output logic             chk_pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             first_err_v,
  output logic [M-1:0]     first_err_a,
  output logic [N-1:0]     first_err_x,
  output logic [M+N-1:0]   first_err_p
);

  chk_state_e state_q, state_d;
  logic [M-1:0]     a_q, a_d;
  logic [N-1:0]     x_q, x_d;
  logic [M+N-1:0]   p_q, p_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] vec_q, vec_d, err_q, err_d;
  logic             fev_q, fev_d;
  logic [M-1:0]     fea_q, fea_d;
  logic [N-1:0]     fex_q, fex_d;
  logic [M+N-1:0]   fep_q, fep_d;

  logic             core_start, core_step, core_last;
  logic [M+N-1:0]   core_product;

  assign core_start = (state_q == ST_IDLE) && in_valid;
  // One extra MULT cycle after the last step is spent latching the compare result.
  assign core_step  = (state_q == ST_MULT) && !core_last;

  shift_add_mult_core #(.M(M), .N(N)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (core_start),
    .step    (core_step),
    .a       (in_a),
    .x       (in_x),
    .last    (core_last),
    .product (core_product)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    x_d     = x_q;
    p_d     = p_q;
    pass_d  = pass_q;
    vec_d   = vec_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fea_d   = fea_q;
    fex_d   = fex_q;
    fep_d   = fep_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_MULT;
          a_d     = in_a;
          x_d     = in_x;
          p_d     = in_p;
        end
      end
      ST_MULT: begin
        if (core_last) begin
          state_d = ST_CMP;
          pass_d  = (core_product == p_q);
        end
      end
      ST_CMP: begin
        state_d = ST_IDLE;
        if (vec_q != '1) vec_d = vec_q + CNT_W'(1);
        if (!pass_q) begin
          if (err_q != '1) err_d = err_q + CNT_W'(1);
          if (!fev_q) begin
            fev_d = 1'b1;
            fea_d = a_q;
            fex_d = x_q;
            fep_d = p_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // clr overrides a coincident CMP update so that vector goes uncounted.
    if (clr) begin
      vec_d = '0;
      err_d = '0;
      fev_d = 1'b0;
      fea_d = '0;
      fex_d = '0;
      fep_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      x_q     <= '0;
      p_q     <= '0;
      pass_q  <= 1'b0;
      vec_q   <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fea_q   <= '0;
      fex_q   <= '0;
      fep_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      x_q     <= x_d;
      p_q     <= p_d;
      pass_q  <= pass_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fea_q   <= fea_d;
      fex_q   <= fex_d;
      fep_q   <= fep_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_MULT) || (state_q == ST_CMP);
  assign chk_done    = (state_q == ST_CMP);
  assign chk_pass    = pass_q;
  assign vec_cnt     = vec_q;
  assign err_cnt     = err_q;
  assign first_err_v = fev_q;
  assign first_err_a = fea_q;
  assign first_err_x = fex_q;
  assign first_err_p = fep_q;

endmodule

// File: tb/tb_array_mult_response_checker.sv
// tb/tb_array_mult_response_checker.sv - self-checking bench for array_mult_response_checker
module tb_array_mult_response_checker;

  logic        clk = 1'b0;
  logic        rst_n, clr, clr4, in_valid;
  logic [7:0]  in_a, in_x;
  logic [15:0] in_p;

  logic        in_ready, busy, chk_done, chk_pass, first_err_v;
  logic [15:0] vec_cnt, err_cnt, first_err_p;
  logic [7:0]  first_err_a, first_err_x;

  logic        b_in_ready, b_busy, b_chk_done, b_chk_pass, b_fv;
  logic [3:0]  b_vec, b_err;
  logic [7:0]  b_fa, b_fx;
  logic [15:0] b_fp;

  array_mult_response_checker #(.M(8), .N(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_x(in_x), .in_p(in_p), .busy(busy), .chk_done(chk_done),
    .chk_pass(chk_pass), .vec_cnt(vec_cnt), .err_cnt(err_cnt), .first_err_v(first_err_v),
    .first_err_a(first_err_a), .first_err_x(first_err_x), .first_err_p(first_err_p)
  );

  array_mult_response_checker #(.M(8), .N(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr4), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_a(in_a), .in_x(in_x), .in_p(in_p), .busy(b_busy), .chk_done(b_chk_done),
    .chk_pass(b_chk_pass), .vec_cnt(b_vec), .err_cnt(b_err), .first_err_v(b_fv),
    .first_err_a(b_fa), .first_err_x(b_fx), .first_err_p(b_fp)
  );

  always #5 clk = ~clk;

  int applied = 0, miscompares = 0, n_checks = 0;
  int m_vec, m_err, m_fa, m_fx, m_fp, m4_vec, m4_err;
  bit m_fv, m4_fv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_vec = 0; m_err = 0; m_fv = 0; m_fa = 0; m_fx = 0; m_fp = 0;
    m4_vec = 0; m4_err = 0; m4_fv = 0;
  endtask

  task automatic model_update(input bit pass, input int a, input int x, input int p, input bit kill4);
    if (m_vec < 65535) m_vec++;
    if (!pass) begin
      if (m_err < 65535) m_err++;
      if (!m_fv) begin m_fv = 1; m_fa = a; m_fx = x; m_fp = p; end
    end
    if (kill4) begin
      m4_vec = 0; m4_err = 0; m4_fv = 0;
    end else begin
      if (m4_vec < 15) m4_vec++;
      if (!pass) begin
        if (m4_err < 15) m4_err++;
        m4_fv = 1;
      end
    end
  endtask

  task automatic check_cnt();
    check("vec_cnt", vec_cnt, m_vec);
    check("err_cnt", err_cnt, m_err);
    check("first_err_v", first_err_v, m_fv);
    if (m_fv) begin
      check("first_err_a", first_err_a, m_fa);
      check("first_err_x", first_err_x, m_fx);
      check("first_err_p", first_err_p, m_fp);
    end
    check("vec_cnt4", b_vec, m4_vec);
    check("err_cnt4", b_err, m4_err);
    check("first_err_v4", b_fv, m4_fv);
  endtask

  // Caller is at a negedge; returns at the negedge of the chk_done cycle.
  task automatic send(input int a, input int x, input int p, input bit hold, input bit clr4_at_done);
    int lat, low;
    bit seen, rdy, exp_pass;
    in_a = a[7:0]; in_x = x[7:0]; in_p = p[15:0]; in_valid = 1'b1;
    rdy = 0;
    for (int i = 0; i < 30; i++) begin
      if (in_ready) begin rdy = 1; break; end
      @(negedge clk);
    end
    check("accept_ready", rdy, 1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
    seen = 0; lat = 0; low = 0;
    for (int i = 0; i < 20; i++) begin
      if (!in_ready) low++;
      if (chk_done) begin seen = 1; break; end
      lat++;
      @(negedge clk);
    end
    exp_pass = ((a * x) == p);
    check("chk_done_seen", seen, 1);
    check("done_latency", lat, 9);
    check("in_ready_low", low, 10);
    check("busy_at_done", busy, 1);
    check("chk_pass", chk_pass, exp_pass);
    check("chk_pass4", b_chk_pass, exp_pass);
    if (clr4_at_done) clr4 = 1'b1;
    model_update(exp_pass, a, x, p, clr4_at_done);
    applied++;
  endtask

  initial begin
    int a, x, p, dones;
    rst_n = 1'b0; clr = 1'b0; clr4 = 1'b0; in_valid = 1'b0;
    in_a = '0; in_x = '0; in_p = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_chk_done", chk_done, 0);
    check("rst_chk_pass", chk_pass, 0);
    check("rst_first_err_a", first_err_a, 0);
    check_cnt();
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic passing vector
    send(3, 5, 15, 0, 0);
    @(negedge clk); check_cnt();

    // 2: corners
    send(0, 0, 0, 0, 0);       @(negedge clk); check_cnt();
    send(255, 255, 65025, 0, 0); @(negedge clk); check_cnt();
    send(255, 1, 255, 0, 0);   @(negedge clk); check_cnt();

    // 3: two failures, first one retained
    send(7, 9, 62, 0, 0);      @(negedge clk); check_cnt();
    send(2, 2, 5, 0, 0);       @(negedge clk); check_cnt();

    // random vectors, some with a single flipped product bit
    for (int i = 0; i < 12; i++) begin
      a = $urandom_range(255, 0);
      x = $urandom_range(255, 0);
      p = a * x;
      if ($urandom_range(1, 0) == 1) p = p ^ (1 << $urandom_range(15, 0));
      send(a, x, p, 0, 0);
      @(negedge clk); check_cnt();
    end

    // idle clr on the wide instance
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    m_vec = 0; m_err = 0; m_fv = 0;
    check_cnt();

    // 4: back-to-back sweep with in_valid held high
    for (int i = 1; i <= 64; i++) begin
      for (int j = 1; j <= 64; j++) begin
        send(i, j, i * j, 1, 0);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("sweep_vec_cnt", vec_cnt, 4096);
    check_cnt();

    // 5: saturation of the narrow instance, then clr coinciding with chk_done
    for (int i = 0; i < 20; i++) begin
      a = $urandom_range(255, 0);
      x = $urandom_range(255, 0);
      send(a, x, (a * x + 1) & 16'hFFFF, 0, 0);
    end
    @(negedge clk);
    check("sat_vec4", b_vec, 15);
    check("sat_err4", b_err, 15);
    check_cnt();
    send(4, 4, 17, 0, 1);
    @(negedge clk);
    clr4 = 1'b0;
    check("clr_vec4", b_vec, 0);
    check("clr_fv4", b_fv, 0);
    check_cnt();

    // 6: reset in the middle of MULT
    in_a = 8'd6; in_x = 8'd7; in_p = 16'd42; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_chk_done", chk_done, 0);
    check("mid_rst_chk_pass", chk_pass, 0);
    check_cnt();
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (chk_done) dones++;
    end
    check("no_done_after_rst", dones, 0);
    send(11, 13, 143, 0, 0);
    @(negedge clk); check_cnt();

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
